keccak_ctrl: RTL and testbench

// Sequencer for the masked Keccak-f[200] core (keccak_top). Takes one shared state via valid/ready,

---
 rtl/keccak_ctrl_pkg.sv | 19 +
 rtl/keccak_ctrl.sv | 150 +++++++++++++++
 tb/tb_keccak_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_ctrl_pkg.sv
// Shared types and default sizing for the masked Keccak-f[200] sequencer.
// Defaults describe a second-order (three-share) core.
package keccak_ctrl_pkg;

    localparam int D_DEF        = 2;
    localparam int STATE_W_DEF  = 200;
    localparam int RAND_W_DEF   = STATE_W_DEF * (D_DEF + 1);
    localparam int LOAD_CYC_DEF = 2;
    localparam int TIMEOUT_DEF  = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/keccak_ctrl.sv
// Sequencer for the masked Keccak-f[200] core: loads shares, runs the core while
// watching fresh randomness, hands the shared result out and then wipes it.
module keccak_ctrl
    import keccak_ctrl_pkg::*;
#(
    parameter int d        = D_DEF,
    parameter int STATE_W  = STATE_W_DEF,
    parameter int RAND_W   = STATE_W * (d + 1),
    parameter int LOAD_CYC = LOAD_CYC_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [STATE_W*(d+1)-1:0] InData,
    input  logic [RAND_W-1:0]        RandIn,
    input  logic                     RandValid,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [STATE_W*(d+1)-1:0] OutData,
    output logic                     Busy,
    output logic                     Err,
    output logic                     CoreReset,
    output logic [STATE_W*(d+1)-1:0] CoreInData,
    output logic [RAND_W-1:0]        CoreFreshRand,
    input  logic                     CoreReady,
    input  logic [STATE_W*(d+1)-1:0] CoreOutData
);

    localparam int SHARES_W = STATE_W * (d + 1);
    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                core_reset_q, core_reset_d;
    logic [SHARES_W-1:0] out_data_q, out_data_d;
    logic [SHARES_W-1:0] core_in_data_q, core_in_data_d;

    // Shares are only ever captured, forwarded or zeroed; no two shares meet in logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        in_ready_d     = in_ready_q;
        out_valid_d    = out_valid_q;
        busy_d         = busy_q;
        err_d          = err_q;
        core_reset_d   = core_reset_q;
        out_data_d     = out_data_q;
        core_in_data_d = core_in_data_q;

        unique case (state_q)
            S_IDLE: begin
                in_ready_d   = 1'b1;
                core_reset_d = 1'b1;
                if (InValid && in_ready_q) begin
                    core_in_data_d = InData;
                    err_d          = 1'b0;
                    cnt_d          = '0;
                    in_ready_d     = 1'b0;
                    busy_d         = 1'b1;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d        = '0;
                    core_reset_d = 1'b0;
                    state_d      = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A finishing core wins over a randomness dropout in the same cycle.
                if (CoreReady) begin
                    out_data_d   = CoreOutData;
                    out_valid_d  = 1'b1;
                    core_reset_d = 1'b1;
                    state_d      = S_DONE;
                end else if (!RandValid || (cnt_q == RUN_LAST)) begin
                    err_d          = 1'b1;
                    core_reset_d   = 1'b1;
                    core_in_data_d = '0;
                    state_d        = S_ERR;
                end
            end
            S_DONE: begin
                if (out_valid_q && OutReady) begin
                    out_valid_d    = 1'b0;
                    out_data_d     = '0;
                    core_in_data_d = '0;
                    busy_d         = 1'b0;
                    in_ready_d     = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            S_ERR: begin
                core_in_data_d = '0;
                busy_d         = 1'b0;
                in_ready_d     = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            core_reset_q   <= 1'b1;
            out_data_q     <= '0;
            core_in_data_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            core_reset_q   <= core_reset_d;
            out_data_q     <= out_data_d;
            core_in_data_q <= core_in_data_d;
        end
    end

    assign InReady       = in_ready_q;
    assign OutValid      = out_valid_q;
    assign OutData       = out_data_q;
    assign Busy          = busy_q;
    assign Err           = err_q;
    assign CoreReset     = core_reset_q;
    assign CoreInData    = core_in_data_q;
    assign CoreFreshRand = RandIn;

endmodule

// File: tb/tb_keccak_ctrl.sv
// Directed bench for keccak_ctrl; the bench itself plays the role of the core
// (drives CoreReady/CoreOutData) so every run length and abort point is exact.
module tb_keccak_ctrl;

    localparam int SW       = 600;
    localparam int RW       = 600;
    localparam int LOAD_CYC = 2;

    logic          Clock     = 1'b0;
    logic          Reset     = 1'b1;
    logic          InValid   = 1'b0;
    logic          RandValid = 1'b1;
    logic          OutReady  = 1'b0;
    logic          CoreReady = 1'b0;
    logic [SW-1:0] InData      = '0;
    logic [SW-1:0] CoreOutData = '0;
    logic [RW-1:0] RandIn      = '0;

    logic          InReady, OutValid, Busy, Err, CoreReset;
    logic [SW-1:0] OutData, CoreInData;
    logic [RW-1:0] CoreFreshRand;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [SW-1:0] in_data;
        logic [SW-1:0] core_out;
        int            ready_at;
        int            drop_at;
        int            hold;
        logic          exp_valid;
        logic          exp_err;
        int            exp_run;
    } vec_t;

    vec_t vecs[7];

    always #5 Clock = ~Clock;

    keccak_ctrl dut (
        .Clock(Clock), .Reset(Reset),
        .InValid(InValid), .InReady(InReady), .InData(InData),
        .RandIn(RandIn), .RandValid(RandValid),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .Busy(Busy), .Err(Err),
        .CoreReset(CoreReset), .CoreInData(CoreInData), .CoreFreshRand(CoreFreshRand),
        .CoreReady(CoreReady), .CoreOutData(CoreOutData)
    );

    task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        testCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic acceptRequest(input string tag, input logic [SW-1:0] data);
        int n;
        n = 0;
        while (InReady !== 1'b1 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        checkBit({tag, "_in_ready"}, InReady, 1'b1);
        InValid = 1'b1;
        InData  = data;
        @(negedge Clock);
        InValid = 1'b0;
    endtask

    task automatic waitLoad(input string tag);
        int loads;
        loads = 0;
        while (CoreReset === 1'b1 && loads < 20) begin
            loads++;
            @(negedge Clock);
        end
        checkInt({tag, "_load_cycles"}, loads, LOAD_CYC);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        int    k;
        logic  held_ok;
        tag = $sformatf("v%0d", idx);
        acceptRequest(tag, v.in_data);
        checkOutput({tag, "_core_in_data"}, CoreInData, v.in_data);
        checkBit({tag, "_err_cleared"}, Err, 1'b0);
        checkBit({tag, "_busy"}, Busy, 1'b1);
        waitLoad(tag);

        k           = 0;
        CoreOutData = v.core_out;
        CoreReady   = (v.ready_at == 0);
        RandValid   = (v.drop_at != 0);
        while (k < 200) begin
            @(negedge Clock);
            if (CoreReset === 1'b1) break;
            k++;
            CoreReady = (v.ready_at == k);
            RandValid = (v.drop_at != k);
        end
        CoreReady = 1'b0;
        RandValid = 1'b1;

        checkInt({tag, "_run_cycles"}, k + 1, v.exp_run);
        checkBit({tag, "_out_valid"}, OutValid, v.exp_valid);
        checkBit({tag, "_err"}, Err, v.exp_err);

        if (v.exp_valid) begin
            held_ok = 1'b1;
            repeat (v.hold) begin
                @(negedge Clock);
                if (OutData !== v.core_out || InReady !== 1'b0 || OutValid !== 1'b1) held_ok = 1'b0;
            end
            checkBit({tag, "_hold_stable"}, held_ok, 1'b1);
            checkOutput({tag, "_out_data"}, OutData, v.core_out);
            OutReady = 1'b1;
            @(negedge Clock);
            OutReady = 1'b0;
            checkBit({tag, "_out_valid_cleared"}, OutValid, 1'b0);
            checkOutput({tag, "_out_data_zeroed"}, OutData, '0);
            checkOutput({tag, "_core_in_zeroed"}, CoreInData, '0);
            checkBit({tag, "_in_ready_back"}, InReady, 1'b1);
        end else begin
            checkBit({tag, "_core_reset_err"}, CoreReset, 1'b1);
            checkOutput({tag, "_out_data_err"}, OutData, '0);
            @(negedge Clock);
            checkBit({tag, "_err_sticky"}, Err, 1'b1);
            checkBit({tag, "_out_valid_err"}, OutValid, 1'b0);
            checkBit({tag, "_idle_after_err"}, InReady, 1'b1);
            checkBit({tag, "_busy_after_err"}, Busy, 1'b0);
            checkOutput({tag, "_core_in_err"}, CoreInData, '0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SW-1:0] data_a, data_b;
        logic [RW-1:0] rnd;
        logic          ok;

        vecs[0] = '{{200'h5a5a5a5a5a5a5a5a, 200'h33cc33cc33cc33cc,
                     200'hffffffffffffffffffffffffffffffff0123456789abcdef01},
                    {200'h0, 200'h0, 200'he090c8c5e596d3421d2fcc695838626cbb365352811837480f},
                    0, -1, 10, 1'b1, 1'b0, 1};
        vecs[1] = '{{200'h1111, 200'h2222, 200'h3333},
                    {200'haaaa, 200'hbbbb, 200'hcccc}, 23, -1, 2, 1'b1, 1'b0, 24};
        vecs[2] = '{{200'h44, 200'h55, 200'h66},
                    {200'hdead, 200'hbeef, 200'hf00d}, 30, 5, 0, 1'b0, 1'b1, 6};
        vecs[3] = '{{200'h77, 200'h88, 200'h99},
                    {200'h0badf00d, 200'hcafe, 200'h1234}, 7, 7, 1, 1'b1, 1'b0, 8};
        vecs[4] = '{{200'habc, 200'hdef, 200'h123},
                    {200'h1, 200'h2, 200'h3}, -1, -1, 0, 1'b0, 1'b1, 64};
        vecs[5] = '{{200'hf0, 200'h0f, 200'hff},
                    {200'h9, 200'h8, 200'h7}, -1, 0, 0, 1'b0, 1'b1, 1};
        vecs[6] = '{{SW{1'b0}},
                    {200'h13579bdf, 200'h2468ace0, 200'hfedcba98}, 12, -1, 3, 1'b1, 1'b0, 13};

        #1 Reset = 1'b0;
        repeat (2) @(negedge Clock);
        checkBit("reset_in_ready", InReady, 1'b0);
        checkBit("reset_out_valid", OutValid, 1'b0);
        checkBit("reset_busy", Busy, 1'b0);
        checkBit("reset_err", Err, 1'b0);
        checkBit("reset_core_reset", CoreReset, 1'b1);
        checkOutput("reset_core_in", CoreInData, '0);
        checkOutput("reset_out_data", OutData, '0);
        Reset = 1'b1;

        rnd    = {20{30'h2b5c19e7}};
        RandIn = rnd;
        #1;
        checkOutput("fresh_rand_passthru", CoreFreshRand, rnd);
        @(negedge Clock);

        for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

        // Reset pulled low in the middle of a run.
        acceptRequest("rst", {200'h77, 200'h66, 200'h55});
        waitLoad("rst");
        repeat (3) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        checkBit("rst_out_valid", OutValid, 1'b0);
        checkBit("rst_busy", Busy, 1'b0);
        checkBit("rst_core_reset", CoreReset, 1'b1);
        checkOutput("rst_core_in", CoreInData, '0);
        checkBit("rst_in_ready", InReady, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        applyStimulus(6, vecs[6]);

        // A request held during DONE must wait for the cycle after the handshake.
        data_a = {200'ha1, 200'ha2, 200'ha3};
        data_b = {200'hb1, 200'hb2, 200'hb3};
        acceptRequest("done", data_a);
        waitLoad("done");
        CoreOutData = {200'hc1, 200'hc2, 200'hc3};
        CoreReady   = 1'b1;
        @(negedge Clock);
        CoreReady = 1'b0;
        checkBit("done_out_valid", OutValid, 1'b1);
        InValid = 1'b1;
        InData  = data_b;
        ok      = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            if (InReady !== 1'b0 || CoreInData !== data_a) ok = 1'b0;
        end
        checkBit("done_ignores_request", ok, 1'b1);
        OutReady = 1'b1;
        @(negedge Clock);
        OutReady = 1'b0;
        checkBit("done_in_ready_after_hs", InReady, 1'b1);
        checkBit("done_not_yet_busy", Busy, 1'b0);
        checkOutput("done_core_in_zero", CoreInData, '0);
        @(negedge Clock);
        InValid = 1'b0;
        checkOutput("done_next_accepted", CoreInData, data_b);
        checkBit("done_next_busy", Busy, 1'b1);
        waitLoad("done2");
        CoreReady = 1'b1;
        @(negedge Clock);
        CoreReady = 1'b0;
        checkOutput("done2_out_data", OutData, {200'hc1, 200'hc2, 200'hc3});
        OutReady = 1'b1;
        @(negedge Clock);
        OutReady = 1'b0;
        checkBit("done2_idle", InReady, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
